// File: rtl/riscv_test_monitor_pkg.sv
// Shared types and defaults for the riscv-tests pass/fail monitor.
package riscv_test_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_PASS    = 2'd1,
      ST_FAIL    = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_e;

   localparam logic [4:0]  GP_IDX          = 5'd3;
   localparam logic [31:0] DEF_TOHOST_ADDR = 32'h0000_1000;
   localparam logic [31:0] DEF_END_PC      = 32'h0000_0044;

endpackage

// File: rtl/riscv_test_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: clear, else step unless already at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/riscv_test_monitor.sv
// Pass/fail monitor for riscv-tests runs: shadows gp, snoops tohost stores
// and the end-of-test PC, and flags timeout/hang with a sticky verdict.
module riscv_test_monitor
   import riscv_test_pkg::*;
#(
   parameter logic [31:0] END_PC      = DEF_END_PC,
   parameter logic [31:0] TOHOST_ADDR = DEF_TOHOST_ADDR,
   parameter int unsigned TIMEOUT_CYC = 2500,
   parameter int unsigned HANG_CYC    = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic [31:0] pc_out,
   input  logic [31:0] debug_wb_pc,
   input  logic [3:0]  debug_wb_rf_wen,
   input  logic [4:0]  debug_wb_rf_wnum,
   input  logic [31:0] debug_wb_rf_wdata,
   input  logic        data_we,
   input  logic [31:0] data_waddr,
   input  logic [31:0] data_wdata,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic        timeout,
   output logic [30:0] fail_testnum,
   output logic [31:0] cycle_cnt,
   output logic [31:0] retire_cnt
);

   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
   localparam logic [31:0] HANG_LAST    = 32'(HANG_CYC - 1);

   state_e      state_q, state_d;
   logic        done_q, done_d, pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;
   logic [30:0] fail_testnum_q, fail_testnum_d;
   logic [31:0] gp_shadow_q, gp_shadow_d;
   logic [31:0] last_wb_pc_q, last_wb_pc_d;
   logic [31:0] idle_cnt;

   logic        running, retire, gp_wr, tohost_hit;
   logic [31:0] gp_eff;

   assign running    = (state_q == ST_RUN);
   assign retire     = (debug_wb_pc != last_wb_pc_q);
   assign gp_wr      = (debug_wb_rf_wen != 4'd0) && (debug_wb_rf_wnum == GP_IDX);
   // Same-cycle gp writeback bypasses the shadow so END_PC sees the final value.
   assign gp_eff     = gp_wr ? debug_wb_rf_wdata : gp_shadow_q;
   assign tohost_hit = data_we && (data_waddr == TOHOST_ADDR) && (data_wdata != 32'd0);

   sat_counter #(.W(32)) u_cycle_cnt (
      .clk(clk), .rst_n(rst_n), .clr(clr), .inc(running), .cnt(cycle_cnt)
   );

   sat_counter #(.W(32)) u_retire_cnt (
      .clk(clk), .rst_n(rst_n), .clr(clr), .inc(running && retire), .cnt(retire_cnt)
   );

   // Idle run length restarts on every retire.
   sat_counter #(.W(32)) u_idle_cnt (
      .clk(clk), .rst_n(rst_n), .clr(clr || (running && retire)),
      .inc(running && !retire), .cnt(idle_cnt)
   );

   // Verdict evaluation in RUN; terminal states hold everything until clr/reset.
   always_comb begin
      state_d        = state_q;
      done_d         = done_q;
      pass_d         = pass_q;
      fail_d         = fail_q;
      timeout_d      = timeout_q;
      fail_testnum_d = fail_testnum_q;
      gp_shadow_d    = gp_shadow_q;
      last_wb_pc_d   = last_wb_pc_q;
      if (clr) begin
         state_d        = ST_RUN;
         done_d         = 1'b0;
         pass_d         = 1'b0;
         fail_d         = 1'b0;
         timeout_d      = 1'b0;
         fail_testnum_d = '0;
         gp_shadow_d    = '0;
         last_wb_pc_d   = '0;
      end else if (running) begin
         if (gp_wr)  gp_shadow_d  = debug_wb_rf_wdata;
         if (retire) last_wb_pc_d = debug_wb_pc;
         if (tohost_hit) begin
            done_d = 1'b1;
            if (data_wdata == 32'd1) begin
               state_d = ST_PASS;
               pass_d  = 1'b1;
            end else begin
               state_d        = ST_FAIL;
               fail_d         = 1'b1;
               fail_testnum_d = data_wdata[31:1];
            end
         end else if (pc_out == END_PC) begin
            done_d = 1'b1;
            if (gp_eff == 32'd1) begin
               state_d = ST_PASS;
               pass_d  = 1'b1;
            end else begin
               state_d        = ST_FAIL;
               fail_d         = 1'b1;
               fail_testnum_d = gp_eff[31:1];
            end
         end else if ((!retire && (idle_cnt == HANG_LAST)) || (cycle_cnt == TIMEOUT_LAST)) begin
            state_d   = ST_TIMEOUT;
            done_d    = 1'b1;
            timeout_d = 1'b1;
         end
      end
   end

   // State, verdict flags and shadows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_RUN;
         done_q         <= 1'b0;
         pass_q         <= 1'b0;
         fail_q         <= 1'b0;
         timeout_q      <= 1'b0;
         fail_testnum_q <= '0;
         gp_shadow_q    <= '0;
         last_wb_pc_q   <= '0;
      end else begin
         state_q        <= state_d;
         done_q         <= done_d;
         pass_q         <= pass_d;
         fail_q         <= fail_d;
         timeout_q      <= timeout_d;
         fail_testnum_q <= fail_testnum_d;
         gp_shadow_q    <= gp_shadow_d;
         last_wb_pc_q   <= last_wb_pc_d;
      end
   end

   assign done         = done_q;
   assign pass         = pass_q;
   assign fail         = fail_q;
   assign timeout      = timeout_q;
   assign fail_testnum = fail_testnum_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Self-checking bench for riscv_test_monitor: directed scenarios plus random
// episodes, all compared every cycle against a behavioural model.
module tb_riscv_test_monitor;

   localparam logic [31:0] END_PC = 32'h0000_0044;
   localparam logic [31:0] TOHOST = 32'h0000_1000;
   localparam int          TO_CYC = 2500;
   localparam int          HANG   = 256;

   logic        clk = 1'b0;
   logic        rst_n, clr;
   logic [31:0] pc_out, wb_pc, wb_wdata, waddr, sdata;
   logic [3:0]  wen;
   logic [4:0]  wnum;
   logic        we;
   logic        done, pass, fail, timeout;
   logic [30:0] fail_testnum;
   logic [31:0] cycle_cnt, retire_cnt;

   int n_cmp = 0;
   int n_mis = 0;

   // Model state: verdict 0=running 1=pass 2=fail 3=timeout
   int          m_verdict;
   logic [30:0] m_ftn;
   longint      m_cyc, m_ret, m_idle;
   logic [31:0] m_gp, m_last;

   riscv_test_monitor dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .pc_out(pc_out),
      .debug_wb_pc(wb_pc), .debug_wb_rf_wen(wen), .debug_wb_rf_wnum(wnum),
      .debug_wb_rf_wdata(wb_wdata), .data_we(we), .data_waddr(waddr),
      .data_wdata(sdata), .done(done), .pass(pass), .fail(fail),
      .timeout(timeout), .fail_testnum(fail_testnum), .cycle_cnt(cycle_cnt),
      .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] sat32(input longint v);
      return (v >= 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
   endfunction

   task automatic model_reset();
      m_verdict = 0; m_ftn = '0; m_cyc = 0; m_ret = 0; m_idle = 0;
      m_gp = '0; m_last = '0;
   endtask

   // One clock edge of the monitor's rules, from the bench's own input values.
   task automatic model_clock();
      bit          ret;
      logic [31:0] g;
      if (!rst_n || clr) begin
         model_reset();
         return;
      end
      if (m_verdict != 0) return;
      ret = (wb_pc != m_last);
      g   = (wen != 0 && wnum == 5'd3) ? wb_wdata : m_gp;
      if (we && waddr == TOHOST && sdata != 0) begin
         if (sdata == 1) m_verdict = 1;
         else begin m_verdict = 2; m_ftn = sdata >> 1; end
      end else if (pc_out == END_PC) begin
         if (g == 1) m_verdict = 1;
         else begin m_verdict = 2; m_ftn = g >> 1; end
      end else if (!ret && m_idle == HANG - 1) m_verdict = 3;
      else if (m_cyc == TO_CYC - 1)            m_verdict = 3;
      if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
      if (ret) begin
         if (m_ret < 64'hFFFF_FFFF) m_ret++;
         m_idle = 0;
         m_last = wb_pc;
      end else if (m_idle < 64'hFFFF_FFFF) m_idle++;
      if (wen != 0 && wnum == 5'd3) m_gp = wb_wdata;
   endtask

   task automatic compare_all(input string tag);
      logic [3:0] exp_flags;
      exp_flags = {m_verdict != 0, m_verdict == 1, m_verdict == 2, m_verdict == 3};
      check({tag, ".flags"}, {60'd0, done, pass, fail, timeout}, {60'd0, exp_flags});
      check({tag, ".ftn"},   {33'd0, fail_testnum}, {33'd0, m_ftn});
      check({tag, ".cyc"},   {32'd0, cycle_cnt},    {32'd0, sat32(m_cyc)});
      check({tag, ".ret"},   {32'd0, retire_cnt},   {32'd0, sat32(m_ret)});
   endtask

   task automatic quiet();
      clr = 0; we = 0; waddr = 0; sdata = 0;
      wen = 0; wnum = 0; wb_wdata = 0; pc_out = 32'h0000_0100;
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_clock();
      #1;
      compare_all(tag);
   endtask

   task automatic clear_step();
      quiet(); clr = 1;
      step("clr");
      clr = 0;
   endtask

   initial begin
      int rp, ep;
      rst_n = 0; wb_pc = 0;
      quiet();
      model_reset();
      step("rst"); step("rst");
      check("rst.done", {63'd0, done}, 64'd0);
      rst_n = 1;

      // 1: ten retires, gp=1 on the last, then END_PC -> PASS, retire_cnt=10
      for (int i = 0; i < 10; i++) begin
         quiet(); wb_pc = 32'(4 * (i + 1));
         if (i == 9) begin wen = 4'hF; wnum = 5'd3; wb_wdata = 32'd1; end
         step("t1.run");
      end
      quiet(); pc_out = END_PC;
      step("t1.end");
      check("t1.pass", {63'd0, pass}, 64'd1);
      check("t1.retire", {32'd0, retire_cnt}, 64'd10);
      quiet(); step("t1.hold"); step("t1.hold");

      // 2: gp=7 then END_PC -> FAIL testnum 3
      clear_step(); wb_pc = 0;
      wen = 4'h1; wnum = 5'd3; wb_wdata = 32'd7; step("t2.gp");
      quiet(); pc_out = END_PC; step("t2.end");
      check("t2.fail", {62'd0, fail, pass}, 64'd2);
      check("t2.ftn", {33'd0, fail_testnum}, 64'd3);

      // 3: tohost=0xB, END_PC and gp=1 together -> tohost wins, testnum 5
      clear_step();
      we = 1; waddr = TOHOST; sdata = 32'hB; pc_out = END_PC;
      wen = 4'hF; wnum = 5'd3; wb_wdata = 32'd1;
      step("t3.hit");
      check("t3.fail", {62'd0, fail, pass}, 64'd2);
      check("t3.ftn", {33'd0, fail_testnum}, 64'd5);

      // 4: no retire for 256 cycles -> hang TIMEOUT on the 256th edge, then frozen
      clear_step(); wb_pc = 0;
      for (int i = 1; i <= HANG; i++) begin
         step("t4.idle");
         if (i == HANG - 1) check("t4.pre", {63'd0, timeout}, 64'd0);
      end
      check("t4.timeout", {63'd0, timeout}, 64'd1);
      check("t4.cyc", {32'd0, cycle_cnt}, 64'(HANG));
      for (int i = 0; i < 20; i++) begin
         wb_pc = 32'(i * 8 + 4); wen = 4'h3; wnum = 5'd3; wb_wdata = 32'(i);
         step("t4.frozen");
      end
      check("t4.frz_cyc", {32'd0, cycle_cnt}, 64'(HANG));

      // 5: PASS, then async reset mid-cycle, then a retiring run to TIMEOUT
      clear_step();
      we = 1; waddr = TOHOST; sdata = 32'd1; step("t5.pass");
      quiet(); step("t5.hold");
      #2 rst_n = 0; model_reset();
      #1 compare_all("t5.async");
      check("t5.async_done", {63'd0, done}, 64'd0);
      step("t5.rst"); step("t5.rst"); step("t5.rst");
      rst_n = 1;
      for (int i = 1; i <= TO_CYC; i++) begin
         wb_pc = 32'(4 * i);
         step("t5.run");
         if (i == TO_CYC - 1) check("t5.pre", {63'd0, timeout}, 64'd0);
      end
      check("t5.timeout", {63'd0, timeout}, 64'd1);
      check("t5.cyc", {32'd0, cycle_cnt}, 64'(TO_CYC));

      // 6: clr together with a tohost=1 store -> no verdict, counters zero
      quiet(); clr = 1; we = 1; waddr = TOHOST; sdata = 32'd1;
      step("t6.clr");
      check("t6.done", {63'd0, done}, 64'd0);
      check("t6.cyc", {32'd0, cycle_cnt}, 64'd0);
      check("t6.ret", {32'd0, retire_cnt}, 64'd0);
      quiet(); step("t6.after");

      // Random episodes
      for (int e = 0; e < 10; e++) begin
         clear_step(); wb_pc = 0;
         case (e % 3)
            0: rp = 0;
            1: rp = 50;
            default: rp = 90;
         endcase
         ep = (e < 5) ? 150 : 400;
         for (int c = 0; c < 350; c++) begin
            quiet();
            if ($urandom_range(99) < rp) wb_pc = wb_pc + 32'd4;
            if ($urandom_range(9) == 0) begin
               wen = 4'($urandom_range(15)); wnum = ($urandom_range(1) == 0) ? 5'd3 : 5'($urandom);
               wb_wdata = ($urandom_range(2) == 0) ? 32'd1 : 32'($urandom_range(64));
            end
            if ($urandom_range(ep) == 0) pc_out = END_PC;
            if ($urandom_range(ep) == 0) begin
               we = 1; waddr = ($urandom_range(3) == 0) ? 32'h0000_1004 : TOHOST;
               case ($urandom_range(2))
                  0: sdata = 32'd0;
                  1: sdata = 32'd1;
                  default: sdata = $urandom;
               endcase
            end
            step("rnd");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
